crc16_serial_gen: RTL and testbench
===================================

// Module: crc16_serial_gen
// PURPOSE
//   Serial CRC generator upstream of the whitening stage. Snoops the payload bit
//   stream that the TX FIFO presents to the whitener (fifo_in/fifo_in_valid).
//   When the payload ends, it emits the CRC bits serially on crc_out/crc_out_valid,
//   which drive the whitener's CRC_in/CRC_in_valid directly.
//   Payload is LSB-first per byte. CRC is emitted MSB-first.
// PARAMETERS
//   CRC_W   16       CRC width in bits; must be a multiple of 8 (whitener packs bytes)
//   POLY    16'h8005 generator polynomial, implicit x^CRC_W term omitted
//   INIT    16'hFFFF register value at start of each packet
// PORTS
//   clk            in   1       clock, rising edge
//   rst_n          in   1       asynchronous reset, active low
//   bit_in         in   1       payload bit (same net as whitener fifo_in)
//   bit_in_valid   in   1       payload bit qualifier (same net as whitener fifo_in_valid)
//   clear          in   1       synchronous abort; highest priority after reset
//   crc_out        out  1       CRC bit to whitener CRC_in
//   crc_out_valid  out  1       CRC bit qualifier to whitener CRC_in_valid
//   busy           out  1       high in ACCUM or EMIT
//   err_overrun    out  1       1-cycle pulse: bit_in_valid high while in EMIT
//   err_align      out  1       1-cycle pulse: payload length not a multiple of 8
// BEHAVIOUR
//   Reset: state=IDLE, crc_reg=INIT, shift_reg=0, bit_cnt=0, emit_cnt=0.
//   Reset values: all outputs 0.
//   All outputs come directly from flops. No combinational path from any input to any output.
//   LFSR update on every accepted bit (IDLE or ACCUM with bit_in_valid=1):
//     fb = bit_in ^ crc_reg[CRC_W-1]
//     crc_reg <= {crc_reg[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0)
//   bit_cnt is a 3-bit payload counter, mod 8. It increments on every accepted bit.
//   FSM states:
//     IDLE:  bit_in_valid=1 -> ACCUM. This first bit is absorbed in the same edge,
//            and bit_cnt is set to 1.
//     ACCUM: bit_in_valid=1 -> stay in ACCUM and absorb the bit.
//            bit_in_valid=0 -> EMIT. On this edge:
//              shift_reg <= crc_reg; emit_cnt <= 0; crc_out_valid <= 1.
//              If bit_cnt != 0, err_align pulses on the same edge.
//              The transfer to EMIT happens regardless of err_align.
//     EMIT:  crc_out = shift_reg[CRC_W-1].
//            Each edge: shift_reg <<= 1; emit_cnt++.
//            When emit_cnt == CRC_W-1: -> IDLE; crc_out_valid <= 0; crc_reg <= INIT; bit_cnt <= 0.
//   Latency: let the last payload bit be sampled at edge N.
//     bit_in_valid is low during cycle N+1.
//     The first CRC bit is valid during cycle N+2.
//     The CRC occupies exactly CRC_W consecutive cycles with no bubbles.
//     The one-cycle gap is legal for the whitener, which waits in its "between" state.
//   EMIT with bit_in_valid=1: the bit is ignored; crc_reg and the emission are unaffected.
//     err_overrun pulses once per offending cycle.
//   clear=1, any state: on the next edge, state=IDLE, crc_reg=INIT, counters=0,
//     crc_out_valid=0, and no error pulses. A bit_in_valid in the same cycle is discarded.
//   Back-to-back packets: bit_in_valid may rise in the cycle right after the last CRC bit.
//     In that case IDLE absorbs the bit normally with crc_reg=INIT.
//   Zero-length payload is impossible: IDLE leaves only on a valid bit.
//   Reset asserted mid-EMIT: crc_out_valid drops immediately (asynchronous).
//     No partial CRC resumes after reset.
// TESTING
//   1 INIT=0, payload single bit 1, then valid low -> err_align pulse.
//     CRC_W=16 bits 1000_0000_0000_0101 (0x8005), MSB first, starting 2 cycles after the bit.
//   2 Defaults, payload single bit 0 -> err_align pulse.
//     crc_out sequence = 0x7FFB MSB first; crc_out_valid high exactly 16 cycles.
//   3 Defaults, 8 zero bits -> no err_align.
//     CRC equals the golden serial-model value. The whitener downstream produces exactly 3 bytes.
//   4 Drive bit_in_valid high for 2 cycles at emission bit 5 -> 2 err_overrun pulses.
//     The CRC stream is identical to the undisturbed run from scenario 3.
//   5 Assert clear at emission bit 7 -> crc_out_valid 0 on the next cycle.
//     A following 8-bit packet yields the same CRC as when run from reset.
//   6 Two 8-bit packets, the second starting the cycle after the CRC ends -> both CRCs match the model.
//     busy stays continuously high except during the single EMIT->IDLE edge.

Source files
------------

// File: rtl/crc16_serial_gen_if.sv
// Purpose : payload-snoop / serial-CRC bundle between TX FIFO, CRC generator and whitener.
// Latency : wires only.
// Backpressure: none; the stream is valid-only, the whitener waits on crc_out_valid.
// Ports   : bit_in/bit_in_valid payload snoop, clear abort, crc_out/crc_out_valid CRC stream,
//           busy status, err_overrun/err_align single-cycle error pulses.
interface crc16_serial_gen_if;
    logic bit_in;
    logic bit_in_valid;
    logic clear;
    logic crc_out;
    logic crc_out_valid;
    logic busy;
    logic err_overrun;
    logic err_align;

    modport master (
        output bit_in, bit_in_valid, clear,
        input  crc_out, crc_out_valid, busy, err_overrun, err_align
    );

    modport slave (
        input  bit_in, bit_in_valid, clear,
        output crc_out, crc_out_valid, busy, err_overrun, err_align
    );
endinterface

// File: rtl/crc16_serial_gen.sv
// Purpose : serial CRC over an LSB-first payload bit stream, CRC emitted MSB-first to the whitener.
// Latency : first CRC bit valid two cycles after the last payload bit is sampled; CRC_W cycles, no bubbles.
// Backpressure: none; payload bits arriving during emission are dropped and flagged on err_overrun.
// Ports   : clk, rst_n (async, active low); bus (slave modport) carries bit_in/bit_in_valid,
//           clear, crc_out/crc_out_valid, busy, err_overrun, err_align. All outputs are flops.
module crc16_serial_gen #(
    parameter int               CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = 16'h8005,
    parameter logic [CRC_W-1:0] INIT  = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    crc16_serial_gen_if.slave  bus
);
    localparam int CNT_W = $clog2(CRC_W);
    localparam logic [CNT_W-1:0] EMIT_LAST = CNT_W'(CRC_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EMIT} state_t;

    state_t           state, state_nxt;
    logic [CRC_W-1:0] crc_reg;
    logic [CRC_W-1:0] shift_reg;
    logic [2:0]       bit_cnt;
    logic [CNT_W-1:0] emit_cnt;
    logic             crc_out_valid_q;
    logic             busy_q;
    logic             err_overrun_q;
    logic             err_align_q;

    logic             accept;
    logic             emit_last;
    logic             fb;
    logic [CRC_W-1:0] crc_step;

    assign fb       = bus.bit_in ^ crc_reg[CRC_W-1];
    assign crc_step = {crc_reg[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

    // Next-state and bit-acceptance decode; clear overrides everything.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        emit_last = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.bit_in_valid) begin
                    state_nxt = S_ACCUM;
                    accept    = 1'b1;
                end
            end
            S_ACCUM: begin
                if (bus.bit_in_valid) accept    = 1'b1;
                else                  state_nxt = S_EMIT;
            end
            S_EMIT: begin
                if (emit_cnt == EMIT_LAST) begin
                    emit_last = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (bus.clear) begin
            state_nxt = S_IDLE;
            accept    = 1'b0;
            emit_last = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_reg         <= INIT;
            shift_reg       <= '0;
            bit_cnt         <= '0;
            emit_cnt        <= '0;
            crc_out_valid_q <= 1'b0;
            busy_q          <= 1'b0;
            err_overrun_q   <= 1'b0;
            err_align_q     <= 1'b0;
        end else if (bus.clear) begin
            // shift_reg is zeroed too so crc_out reads 0 outside emission.
            crc_reg         <= INIT;
            shift_reg       <= '0;
            bit_cnt         <= '0;
            emit_cnt        <= '0;
            crc_out_valid_q <= 1'b0;
            busy_q          <= 1'b0;
            err_overrun_q   <= 1'b0;
            err_align_q     <= 1'b0;
        end else begin
            busy_q        <= (state_nxt != S_IDLE);
            err_overrun_q <= (state == S_EMIT) && bus.bit_in_valid;
            err_align_q   <= 1'b0;
            if (accept) begin
                crc_reg <= crc_step;
                bit_cnt <= (state == S_IDLE) ? 3'd1 : bit_cnt + 3'd1;
            end
            case (state)
                S_ACCUM: begin
                    if (!bus.bit_in_valid) begin
                        shift_reg       <= crc_reg;
                        emit_cnt        <= '0;
                        crc_out_valid_q <= 1'b1;
                        err_align_q     <= (bit_cnt != 3'd0);
                    end
                end
                S_EMIT: begin
                    shift_reg <= shift_reg << 1;
                    emit_cnt  <= emit_cnt + CNT_W'(1);
                    if (emit_last) begin
                        crc_out_valid_q <= 1'b0;
                        crc_reg         <= INIT;
                        bit_cnt         <= '0;
                        emit_cnt        <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.crc_out       = shift_reg[CRC_W-1];
    assign bus.crc_out_valid = crc_out_valid_q;
    assign bus.busy          = busy_q;
    assign bus.err_overrun   = err_overrun_q;
    assign bus.err_align     = err_align_q;
endmodule

// File: tb/tb_crc16_serial_gen.sv
// Purpose : self-checking bench for crc16_serial_gen (default INIT and INIT=0 instances).
// Latency : n/a.
// Backpressure: n/a.
module tb_crc16_serial_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic drv_v = 1'b0, drv_b = 1'b0, drv_clr = 1'b0;
    logic sel = 1'b0;
    logic o_vld, o_bit, o_busy, o_ovr, o_align;

    int checks = 0;
    int errors = 0;

    crc16_serial_gen_if bus();
    crc16_serial_gen_if bus0();

    assign bus.bit_in        = drv_b;
    assign bus.bit_in_valid  = drv_v & ~sel;
    assign bus.clear         = drv_clr & ~sel;
    assign bus0.bit_in       = drv_b;
    assign bus0.bit_in_valid = drv_v & sel;
    assign bus0.clear        = drv_clr & sel;

    assign o_vld   = sel ? bus0.crc_out_valid : bus.crc_out_valid;
    assign o_bit   = sel ? bus0.crc_out       : bus.crc_out;
    assign o_busy  = sel ? bus0.busy          : bus.busy;
    assign o_ovr   = sel ? bus0.err_overrun   : bus.err_overrun;
    assign o_align = sel ? bus0.err_align     : bus.err_align;

    crc16_serial_gen #(.CRC_W(16), .POLY(16'h8005), .INIT(16'hFFFF)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    crc16_serial_gen #(.CRC_W(16), .POLY(16'h8005), .INIT(16'h0000)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    typedef struct {
        logic [63:0] bits;
        int          len;
        logic        init0;
        logic [15:0] exp_crc;
        int          exp_align;
    } vec_t;

    vec_t vecs[8];

    // CRC as the remainder of bit-serial polynomial division of the payload.
    function automatic logic [15:0] crc_model(input logic [63:0] bits, input int len,
                                              input logic [15:0] init);
        logic [15:0] r;
        r = init;
        for (int i = 0; i < len; i++) begin
            if (bits[i] != r[15]) r = (r << 1) ^ 16'h8005;
            else                  r = r << 1;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drives one packet and collects the CRC stream. Sampling and driving happen on negedges;
    // the loop index c counts cycles since the first payload bit was presented.
    task automatic run_pkt(input logic [63:0] bits, input int len, input int c0,
                           input bit chain, input bit nxt_b,
                           input int ovr_at, input int ovr_n, input int clr_at,
                           output logic [15:0] crc, output int nv, output int nal,
                           output int nov, output int lat, output int nblo, output bit to);
        bit done;
        crc = '0; nv = 0; nal = 0; nov = 0; lat = -1; nblo = 0; done = 1'b0; to = 1'b1;
        for (int c = c0; c < 300; c++) begin
            @(negedge clk);
            if (o_vld) begin
                if (lat < 0) lat = c;
                crc = {crc[14:0], o_bit};
                nv++;
            end else if (nv > 0) begin
                done = 1'b1;
            end
            if (o_align) nal++;
            if (o_ovr) nov++;
            if (c >= 1 && !o_busy) nblo++;
            drv_clr = 1'b0;
            if (c < len) begin drv_v = 1'b1; drv_b = bits[c]; end
            else         begin drv_v = 1'b0; drv_b = 1'b0;    end
            if (o_vld && (nv - 1) >= ovr_at && (nv - 1) < ovr_at + ovr_n) drv_v = 1'b1;
            if (o_vld && (nv - 1) == clr_at) drv_clr = 1'b1;
            if (done) begin
                to = 1'b0;
                if (chain) begin drv_v = 1'b1; drv_b = nxt_b; end
                break;
            end
        end
    endtask

    initial begin
        logic [15:0] crc, exp;
        int nv, nal, nov, lat, nblo;
        bit to;
        logic [63:0] bits, bits2;
        int len;

        vecs[0] = '{64'h1, 1, 1'b1, 16'h8005, 1};
        vecs[1] = '{64'h0, 1, 1'b0, 16'h7FFB, 1};
        vecs[2] = '{64'h1, 1, 1'b0, 16'hFFFE, 1};
        vecs[3] = '{64'h0, 2, 1'b0, 16'hFFF6, 1};
        vecs[4] = '{64'h3, 2, 1'b1, 16'h000A, 1};
        vecs[5] = '{64'h0, 8, 1'b0, crc_model(64'h0, 8, 16'hFFFF), 0};
        vecs[6] = '{64'hA5, 8, 1'b0, crc_model(64'hA5, 8, 16'hFFFF), 0};
        vecs[7] = '{64'h1234, 16, 1'b0, crc_model(64'h1234, 16, 16'hFFFF), 0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst crc_out_valid", 32'(o_vld), 0);
        chk("rst crc_out", 32'(o_bit), 0);
        chk("rst busy", 32'(o_busy), 0);
        chk("rst err_overrun", 32'(o_ovr), 0);
        chk("rst err_align", 32'(o_align), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            sel = vecs[i].init0;
            run_pkt(vecs[i].bits, vecs[i].len, 0, 1'b0, 1'b0, -1, 0, -1,
                    crc, nv, nal, nov, lat, nblo, to);
            chk($sformatf("vec%0d timeout", i), 32'(to), 0);
            chk($sformatf("vec%0d crc", i), 32'(crc), 32'(vecs[i].exp_crc));
            chk($sformatf("vec%0d valid_cycles", i), 32'(nv), 16);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].len + 1));
            chk($sformatf("vec%0d err_align", i), 32'(nal), 32'(vecs[i].exp_align));
            chk($sformatf("vec%0d err_overrun", i), 32'(nov), 0);
        end
        sel = 1'b0;

        // Overrun at emission bits 5 and 6: stream unchanged, two pulses
        run_pkt(64'h0, 8, 0, 1'b0, 1'b0, 5, 2, -1, crc, nv, nal, nov, lat, nblo, to);
        chk("ovr timeout", 32'(to), 0);
        chk("ovr crc", 32'(crc), 32'(crc_model(64'h0, 8, 16'hFFFF)));
        chk("ovr valid_cycles", 32'(nv), 16);
        chk("ovr pulses", 32'(nov), 2);

        // Clear at emission bit 7, then a clean packet
        run_pkt(64'h0, 8, 0, 1'b0, 1'b0, -1, 0, 7, crc, nv, nal, nov, lat, nblo, to);
        chk("clr timeout", 32'(to), 0);
        chk("clr valid_cycles", 32'(nv), 8);
        chk("clr err_overrun", 32'(nov), 0);
        chk("clr err_align", 32'(nal), 0);
        chk("clr busy_after", 32'(o_busy), 0);
        run_pkt(64'h5A, 8, 0, 1'b0, 1'b0, -1, 0, -1, crc, nv, nal, nov, lat, nblo, to);
        chk("post_clr crc", 32'(crc), 32'(crc_model(64'h5A, 8, 16'hFFFF)));
        chk("post_clr valid_cycles", 32'(nv), 16);

        // Back-to-back packets; busy low only in the single IDLE cycle between them
        bits  = 64'h3C;
        bits2 = 64'hC3;
        run_pkt(bits, 8, 0, 1'b1, bits2[0], -1, 0, -1, crc, nv, nal, nov, lat, nblo, to);
        chk("b2b1 crc", 32'(crc), 32'(crc_model(bits, 8, 16'hFFFF)));
        chk("b2b1 busy_low", 32'(nblo), 1);
        run_pkt(bits2, 8, 1, 1'b0, 1'b0, -1, 0, -1, crc, nv, nal, nov, lat, nblo, to);
        chk("b2b2 timeout", 32'(to), 0);
        chk("b2b2 crc", 32'(crc), 32'(crc_model(bits2, 8, 16'hFFFF)));
        chk("b2b2 latency", 32'(lat), 9);
        chk("b2b2 busy_low", 32'(nblo), 1);

        // Asynchronous reset mid-emission
        bits = 64'hA5;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drv_v = 1'b1; drv_b = bits[i];
        end
        @(negedge clk);
        drv_v = 1'b0; drv_b = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_emit valid", 32'(o_vld), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst valid", 32'(o_vld), 0);
        chk("async_rst busy", 32'(o_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_pkt(64'h0F, 8, 0, 1'b0, 1'b0, -1, 0, -1, crc, nv, nal, nov, lat, nblo, to);
        chk("post_rst crc", 32'(crc), 32'(crc_model(64'h0F, 8, 16'hFFFF)));
        chk("post_rst valid_cycles", 32'(nv), 16);

        // Randomized packets against the model
        for (int k = 0; k < 20; k++) begin
            len  = int'($urandom_range(48, 1));
            if (k % 3 == 0) len = 8 * int'($urandom_range(6, 1));
            bits = {$urandom, $urandom};
            exp  = crc_model(bits, len, 16'hFFFF);
            run_pkt(bits, len, 0, 1'b0, 1'b0, -1, 0, -1, crc, nv, nal, nov, lat, nblo, to);
            chk($sformatf("rnd%0d timeout", k), 32'(to), 0);
            chk($sformatf("rnd%0d crc", k), 32'(crc), 32'(exp));
            chk($sformatf("rnd%0d valid_cycles", k), 32'(nv), 16);
            chk($sformatf("rnd%0d latency", k), 32'(lat), 32'(len + 1));
            chk($sformatf("rnd%0d err_align", k), 32'(nal), (len % 8 != 0) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
